hazard_ctrl: RTL
================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter MDU_LAT, default 4, is the number of cycles a multi-cycle MDU instruction occupies EX; legal range 2..16.
REQ-002 clk  input  1  pipeline clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 rf_ra0_id, rf_ra1_id  input  5  source register addresses of the instruction in ID.
REQ-005 rf_re0_id, rf_re1_id  input  1  ID instruction actually reads ra0/ra1.
REQ-006 rf_we_ex  input  1  EX instruction writes the register file.
REQ-007 rf_wa_ex  input  5  EX destination register.
REQ-008 mem_re_ex  input  1  EX instruction is a load.
REQ-009 npc_sel_ex  input  1  EX resolved a taken branch or jump.
REQ-010 mdu_start_ex  input  1  EX holds a multi-cycle MDU instruction.
REQ-011 mem_busy  input  1  data memory cannot complete the MEM access this cycle.
REQ-012 stall_pc, stall_if_id, stall_id_ex, stall_ex_mem  output  1 each  hold the named register this cycle.
REQ-013 flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb  output  1 each  load a bubble into the named register this cycle.
REQ-014 mdu_done  output  1  one-cycle pulse in the final EX cycle of an MDU instruction.
REQ-015 stall_cnt  output  32  count of cycles with stall_pc high.

Function
REQ-016 FSM states: IDLE, MDU_BUSY; 4-bit down-counter cnt.
REQ-017 All stall/flush outputs and mdu_done are combinational from state, cnt and inputs; no added latency.
REQ-018 Priority, highest first: mem_busy, MDU (mdu_start_ex in IDLE or state MDU_BUSY), npc_sel_ex, load-use.
REQ-019 mem_busy=1: stall_pc, stall_if_id, stall_id_ex, stall_ex_mem=1, flush_mem_wb=1, all other flushes 0, mdu_done=0, FSM and cnt hold.
REQ-020 IDLE with mdu_start_ex=1: stall_pc, stall_if_id, stall_id_ex=1, flush_ex_mem=1, cnt <= MDU_LAT-2, next state MDU_BUSY.
REQ-021 MDU_BUSY with cnt!=0: same stall/flush set as REQ-020, cnt decrements.
REQ-022 MDU_BUSY with cnt==0: mdu_done=1, no stall/flush, next state IDLE; mdu_start_ex ignored in MDU_BUSY.
REQ-023 Net effect: MDU instruction resides in EX exactly MDU_LAT cycles; MDU_LAT-1 stall cycles.
REQ-024 Branch (npc_sel_ex=1, not overridden): flush_if_id=1, flush_id_ex=1, no stalls; a simultaneous load-use is suppressed (wrong path).
REQ-025 Load-use: mem_re_ex & rf_we_ex & rf_wa_ex!=0 & ((rf_re0_id & rf_ra0_id==rf_wa_ex) | (rf_re1_id & rf_ra1_id==rf_wa_ex)) -> stall_pc=1, stall_if_id=1, flush_id_ex=1 for that cycle.
REQ-026 No condition active: all stall/flush outputs 0.
REQ-027 A register is never both stalled and flushed in the same cycle.
REQ-028 stall_cnt increments by 1 on every edge where stall_pc=1; wraps 0xFFFF_FFFF -> 0.

Reset
REQ-029 rst=1 forces state IDLE, cnt=0, stall_cnt=0 immediately, independent of clk.
REQ-030 During reset all stall/flush outputs and mdu_done are 0; in-progress MDU sequence is abandoned.
REQ-031 First rising edge after rst deassertion evaluates from IDLE.

Structure
REQ-032 FSM state encoding and MDU_LAT default belong in the shared pipeline package.
REQ-033 One sub-module, mdu_timer (counter, load, zero-detect), is natural; the FSM and hazard logic remain top-level.

Verification
REQ-034 Load-use: mem_re_ex=1, rf_we_ex=1, rf_wa_ex=5, rf_re0_id=1, rf_ra0_id=5 -> stall_pc, stall_if_id, flush_id_ex high 1 cycle; stall_cnt +1.
REQ-035 Load to x0: same with rf_wa_ex=0, rf_ra0_id=0 -> all outputs 0.
REQ-036 MDU, MDU_LAT=4: mdu_start_ex held high -> stalls 3 cycles, mdu_done in cycle 4, stall_cnt +3, IDLE afterwards.
REQ-037 npc_sel_ex and load-use same cycle -> flush_if_id, flush_id_ex only; no stall.
REQ-038 mem_busy high 2 cycles in mid-MDU at cnt=1 -> all four stalls + flush_mem_wb, cnt holds at 1, MDU completes 2 cycles late.
REQ-039 rst asserted mid-MDU between edges -> outputs 0 at once, state IDLE, stall_cnt 0.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions for hazard control: FSM encoding and MDU timing.
package hazard_ctrl_pkg;

    typedef enum logic {
        IDLE     = 1'b0,
        MDU_BUSY = 1'b1
    } hz_state_t;

    localparam int unsigned MDU_LAT_DEF = 4;
    localparam int unsigned MDU_CNT_W   = 4;

endpackage

// File: rtl/hazard_ctrl_mdu_timer.sv
// Down-counter tracking the remaining EX cycles of a multi-cycle MDU op.
module mdu_timer
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = MDU_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic [WIDTH-1:0] cnt,
    output logic             zero
);

    // Load takes precedence over decrement; otherwise the count holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec) begin
            cnt <= cnt - WIDTH'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory wait, MDU occupancy, branch and load-use.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned MDU_LAT = MDU_LAT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rf_ra0_id,
    input  logic [4:0]  rf_ra1_id,
    input  logic        rf_re0_id,
    input  logic        rf_re1_id,
    input  logic        rf_we_ex,
    input  logic [4:0]  rf_wa_ex,
    input  logic        mem_re_ex,
    input  logic        npc_sel_ex,
    input  logic        mdu_start_ex,
    input  logic        mem_busy,
    output logic        stall_pc,
    output logic        stall_if_id,
    output logic        stall_id_ex,
    output logic        stall_ex_mem,
    output logic        flush_if_id,
    output logic        flush_id_ex,
    output logic        flush_ex_mem,
    output logic        flush_mem_wb,
    output logic        mdu_done,
    output logic [31:0] stall_cnt
);

    // The first EX cycle is spent in IDLE, the last with cnt==0.
    localparam logic [MDU_CNT_W-1:0] LOAD_VAL = MDU_CNT_W'(MDU_LAT - 2);

    hz_state_t              state;
    hz_state_t              next_state;
    logic                   tmr_load;
    logic                   tmr_dec;
    logic                   tmr_zero;
    logic [MDU_CNT_W-1:0]   tmr_cnt;
    logic                   load_use;

    mdu_timer #(
        .WIDTH (MDU_CNT_W)
    ) u_mdu_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (LOAD_VAL),
        .dec      (tmr_dec),
        .cnt      (tmr_cnt),
        .zero     (tmr_zero)
    );

    // Load in EX whose destination (not x0) is read by the ID instruction.
    always_comb begin
        load_use = mem_re_ex && rf_we_ex && (rf_wa_ex != 5'd0) &&
                   ((rf_re0_id && (rf_ra0_id == rf_wa_ex)) ||
                    (rf_re1_id && (rf_ra1_id == rf_wa_ex)));
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Prioritised hazard resolution; reset forces every control output low.
    always_comb begin
        stall_pc     = 1'b0;
        stall_if_id  = 1'b0;
        stall_id_ex  = 1'b0;
        stall_ex_mem = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        flush_ex_mem = 1'b0;
        flush_mem_wb = 1'b0;
        mdu_done     = 1'b0;
        tmr_load     = 1'b0;
        tmr_dec      = 1'b0;
        next_state   = state;
        if (!rst) begin
            if (mem_busy) begin
                stall_pc     = 1'b1;
                stall_if_id  = 1'b1;
                stall_id_ex  = 1'b1;
                stall_ex_mem = 1'b1;
                flush_mem_wb = 1'b1;
            end else if (state == MDU_BUSY) begin
                if (tmr_zero) begin
                    mdu_done   = 1'b1;
                    next_state = IDLE;
                end else begin
                    stall_pc     = 1'b1;
                    stall_if_id  = 1'b1;
                    stall_id_ex  = 1'b1;
                    flush_ex_mem = 1'b1;
                    tmr_dec      = 1'b1;
                end
            end else if (mdu_start_ex) begin
                stall_pc     = 1'b1;
                stall_if_id  = 1'b1;
                stall_id_ex  = 1'b1;
                flush_ex_mem = 1'b1;
                tmr_load     = 1'b1;
                next_state   = MDU_BUSY;
            end else if (npc_sel_ex) begin
                flush_if_id = 1'b1;
                flush_id_ex = 1'b1;
            end else if (load_use) begin
                stall_pc    = 1'b1;
                stall_if_id = 1'b1;
                flush_id_ex = 1'b1;
            end
        end
    end

    // Running count of PC-stall cycles, wrapping naturally at 32 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall_pc) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

endmodule
